// File: rtl/ext_b_resp_gen_ipa.sv
// AXI write-response generator: pairs accepted AW info with write-burst completions in order.
// Optional macro EXT_B_RESP_SLVERR_EN stores per-burst error flags and reports SLVERR on B.
module ext_b_resp_gen_ipa #(
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 6,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    aw_valid_i,
    input  logic [ID_WIDTH-1:0]     aw_id_i,
    input  logic [USER_WIDTH-1:0]   aw_user_i,
    output logic                    aw_ready_o,
    input  logic                    wl_valid_i,
    input  logic                    wl_err_i,
    output logic                    wl_ready_o,
    output logic                    b_valid_o,
    output logic [1:0]              b_resp_o,
    output logic [ID_WIDTH-1:0]     b_id_o,
    output logic [USER_WIDTH-1:0]   b_user_o,
    input  logic                    b_ready_i,
    output logic [$clog2(DEPTH):0]  outstanding_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AW_W  = ID_WIDTH + USER_WIDTH;

    logic [AW_W-1:0]       aw_mem_q [DEPTH];
    logic [AW_W-1:0]       aw_mem_d [DEPTH];
    logic [PTR_W-1:0]      aw_wr_q, aw_wr_d, aw_rd_q, aw_rd_d;
    logic [CNT_W-1:0]      aw_cnt_q, aw_cnt_d;
    logic [CNT_W-1:0]      wl_cnt_q, wl_cnt_d;
    logic                  b_valid_q, b_valid_d;
    logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [USER_WIDTH-1:0] b_user_q, b_user_d;

    logic                  aw_push, wl_push, load;
    logic [AW_W-1:0]       aw_head;

    assign aw_ready_o    = (aw_cnt_q != CNT_W'(DEPTH));
    assign wl_ready_o    = (wl_cnt_q != CNT_W'(DEPTH));
    assign aw_push       = aw_valid_i && aw_ready_o;
    assign wl_push       = wl_valid_i && wl_ready_o;
    // An entry pushed this cycle into an empty FIFO is forwarded straight to the B register.
    assign load          = ((aw_cnt_q != '0) || aw_push) && ((wl_cnt_q != '0) || wl_push)
                           && (!b_valid_q || b_ready_i);
    assign aw_head       = (aw_cnt_q == '0) ? {aw_id_i, aw_user_i} : aw_mem_q[aw_rd_q];

    assign b_valid_o     = b_valid_q;
    assign b_id_o        = b_id_q;
    assign b_user_o      = b_user_q;
    assign outstanding_o = aw_cnt_q + CNT_W'(b_valid_q);

    always_comb begin
        aw_mem_d = aw_mem_q;
        aw_wr_d  = aw_wr_q;
        aw_rd_d  = aw_rd_q;
        if (aw_push) begin
            aw_mem_d[aw_wr_q] = {aw_id_i, aw_user_i};
            aw_wr_d           = aw_wr_q + PTR_W'(1);
        end
        if (load) begin
            aw_rd_d = aw_rd_q + PTR_W'(1);
        end
        aw_cnt_d  = aw_cnt_q + CNT_W'(aw_push) - CNT_W'(load);
        wl_cnt_d  = wl_cnt_q + CNT_W'(wl_push) - CNT_W'(load);
        b_valid_d = b_valid_q;
        b_id_d    = b_id_q;
        b_user_d  = b_user_q;
        if (load) begin
            b_valid_d = 1'b1;
            b_id_d    = aw_head[AW_W-1:USER_WIDTH];
            b_user_d  = aw_head[USER_WIDTH-1:0];
        end else if (b_ready_i) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                aw_mem_q[i] <= '0;
            end
            aw_wr_q   <= '0;
            aw_rd_q   <= '0;
            aw_cnt_q  <= '0;
            wl_cnt_q  <= '0;
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_user_q  <= '0;
        end else begin
            aw_mem_q  <= aw_mem_d;
            aw_wr_q   <= aw_wr_d;
            aw_rd_q   <= aw_rd_d;
            aw_cnt_q  <= aw_cnt_d;
            wl_cnt_q  <= wl_cnt_d;
            b_valid_q <= b_valid_d;
            b_id_q    <= b_id_d;
            b_user_q  <= b_user_d;
        end
    end

`ifdef EXT_B_RESP_SLVERR_EN
    logic             err_mem_q [DEPTH];
    logic             err_mem_d [DEPTH];
    logic [PTR_W-1:0] wl_wr_q, wl_wr_d, wl_rd_q, wl_rd_d;
    logic [1:0]       b_resp_q, b_resp_d;
    logic             err_head;

    assign err_head = (wl_cnt_q == '0) ? wl_err_i : err_mem_q[wl_rd_q];
    assign b_resp_o = b_resp_q;

    always_comb begin
        err_mem_d = err_mem_q;
        wl_wr_d   = wl_wr_q;
        wl_rd_d   = wl_rd_q;
        b_resp_d  = b_resp_q;
        if (wl_push) begin
            err_mem_d[wl_wr_q] = wl_err_i;
            wl_wr_d            = wl_wr_q + PTR_W'(1);
        end
        if (load) begin
            wl_rd_d  = wl_rd_q + PTR_W'(1);
            b_resp_d = err_head ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                err_mem_q[i] <= 1'b0;
            end
            wl_wr_q  <= '0;
            wl_rd_q  <= '0;
            b_resp_q <= 2'b00;
        end else begin
            err_mem_q <= err_mem_d;
            wl_wr_q   <= wl_wr_d;
            wl_rd_q   <= wl_rd_d;
            b_resp_q  <= b_resp_d;
        end
    end
`else
    // Without error reporting the completion FIFO degenerates to a counter.
    logic unused_err;
    assign unused_err = wl_err_i;
    assign b_resp_o   = 2'b00;
`endif

endmodule

// File: tb/tb_ext_b_resp_gen_ipa.sv
// Directed self-checking bench for ext_b_resp_gen_ipa; honours EXT_B_RESP_SLVERR_EN.
module tb_ext_b_resp_gen_ipa;

    localparam logic [1:0] ERR_RESP =
`ifdef EXT_B_RESP_SLVERR_EN
        2'b10;
`else
        2'b00;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       aw_valid_i;
    logic [3:0] aw_id_i;
    logic [5:0] aw_user_i;
    logic       aw_ready_o;
    logic       wl_valid_i;
    logic       wl_err_i;
    logic       wl_ready_o;
    logic       b_valid_o;
    logic [1:0] b_resp_o;
    logic [3:0] b_id_o;
    logic [5:0] b_user_o;
    logic       b_ready_i;
    logic [2:0] outstanding_o;

    int checks = 0;
    int errors = 0;

    ext_b_resp_gen_ipa #(.ID_WIDTH(4), .USER_WIDTH(6), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_id_i(aw_id_i), .aw_user_i(aw_user_i), .aw_ready_o(aw_ready_o),
        .wl_valid_i(wl_valid_i), .wl_err_i(wl_err_i), .wl_ready_o(wl_ready_o),
        .b_valid_o(b_valid_o), .b_resp_o(b_resp_o), .b_id_o(b_id_o), .b_user_o(b_user_o),
        .b_ready_i(b_ready_i), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic awv, input logic [3:0] id, input logic [5:0] user,
                                 input logic wlv, input logic err, input logic br);
        aw_valid_i = awv;
        aw_id_i    = id;
        aw_user_i  = user;
        wl_valid_i = wlv;
        wl_err_i   = err;
        b_ready_i  = br;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_bvalid"}, b_valid_o, 0);
        checkOutput({tag, "_bresp"}, b_resp_o, 0);
        checkOutput({tag, "_bid"}, b_id_o, 0);
        checkOutput({tag, "_buser"}, b_user_o, 0);
        checkOutput({tag, "_outst"}, outstanding_o, 0);
        checkOutput({tag, "_awrdy"}, aw_ready_o, 1);
        checkOutput({tag, "_wlrdy"}, wl_ready_o, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] ids3 [3];
        logic       errs3 [3];
        logic [1:0] resp3 [3];
        logic [2:0] outst4 [4];

        rst_ni = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #12;
        checkResetValues("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Single AW then completion two cycles later
        applyStimulus(1, 4'd3, 6'h15, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t1_c1_valid", b_valid_o, 0);
        checkOutput("t1_c1_outst", outstanding_o, 1);
        step();
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("t1_c2_valid", b_valid_o, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t1_c3_valid", b_valid_o, 1);
        checkOutput("t1_c3_id", b_id_o, 3);
        checkOutput("t1_c3_user", b_user_o, 6'h15);
        checkOutput("t1_c3_resp", b_resp_o, 0);
        checkOutput("t1_c3_outst", outstanding_o, 1);
        step();
        checkOutput("t1_c4_valid", b_valid_o, 0);
        checkOutput("t1_c4_outst", outstanding_o, 0);

        // Fill the AW FIFO, attempt an overflow, then drain in order
        for (int i = 1; i <= 4; i++) begin
            checkOutput("t2_awrdy_fill", aw_ready_o, 1);
            applyStimulus(1, 4'(i), 6'(16 + i), 0, 0, 1);
            step();
        end
        checkOutput("t2_awrdy_full", aw_ready_o, 0);
        checkOutput("t2_outst_full", outstanding_o, 4);
        applyStimulus(1, 4'd5, 6'h3F, 0, 0, 1);
        step();
        checkOutput("t2_stall_outst", outstanding_o, 4);
        checkOutput("t2_stall_awrdy", aw_ready_o, 0);
        checkOutput("t2_stall_valid", b_valid_o, 0);
        outst4[0] = 3'd4; outst4[1] = 3'd3; outst4[2] = 3'd2; outst4[3] = 3'd1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 1);
            step();
            checkOutput("t2_drain_valid", b_valid_o, 1);
            checkOutput("t2_drain_id", b_id_o, 4'(k + 1));
            checkOutput("t2_drain_user", b_user_o, 6'(17 + k));
            checkOutput("t2_drain_outst", outstanding_o, outst4[k]);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        checkOutput("t2_end_valid", b_valid_o, 0);
        checkOutput("t2_end_outst", outstanding_o, 0);
        checkOutput("t2_end_awrdy", aw_ready_o, 1);

        // Backpressure: B must hold for five cycles, then one handshake
        applyStimulus(1, 4'd7, 6'h2A, 1, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("t3_hold_valid", b_valid_o, 1);
            checkOutput("t3_hold_payload", {b_resp_o, b_id_o, b_user_o}, {ERR_RESP, 4'd7, 6'h2A});
            checkOutput("t3_hold_outst", outstanding_o, 1);
            if (c < 4) step();
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        checkOutput("t3_done_valid", b_valid_o, 0);
        checkOutput("t3_done_outst", outstanding_o, 0);

        // Error response mapping for ids 5,6,7
        ids3[0] = 4'd5; ids3[1] = 4'd6; ids3[2] = 4'd7;
        errs3[0] = 1'b0; errs3[1] = 1'b1; errs3[2] = 1'b0;
        resp3[0] = 2'b00; resp3[1] = ERR_RESP; resp3[2] = 2'b00;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, ids3[k], 6'h01, 1, errs3[k], 1);
            step();
            checkOutput("t4_valid", b_valid_o, 1);
            checkOutput("t4_id", b_id_o, ids3[k]);
            checkOutput("t4_resp", b_resp_o, resp3[k]);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        checkOutput("t4_end_valid", b_valid_o, 0);

        // Completions ahead of their AWs
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 1);
            step();
            checkOutput("t5_early_valid", b_valid_o, 0);
            checkOutput("t5_early_outst", outstanding_o, 0);
        end
        applyStimulus(1, 4'd9, 6'h09, 0, 0, 1);
        step();
        checkOutput("t5_b9_valid", b_valid_o, 1);
        checkOutput("t5_b9_id", b_id_o, 9);
        applyStimulus(1, 4'd10, 6'h0A, 0, 0, 1);
        step();
        checkOutput("t5_b10_valid", b_valid_o, 1);
        checkOutput("t5_b10_id", b_id_o, 10);
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        checkOutput("t5_end_valid", b_valid_o, 0);

        // Reset in the middle of traffic discards everything
        applyStimulus(1, 4'd1, 6'h11, 1, 0, 0);
        step();
        applyStimulus(1, 4'd2, 6'h12, 1, 0, 0);
        step();
        applyStimulus(1, 4'd3, 6'h13, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_pre_outst", outstanding_o, 3);
        checkOutput("t6_pre_valid", b_valid_o, 1);
        checkOutput("t6_pre_id", b_id_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkResetValues("t6_rst");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 1, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t6_post_valid0", b_valid_o, 0);
        step();
        checkOutput("t6_post_valid1", b_valid_o, 0);
        checkOutput("t6_post_outst", outstanding_o, 0);
        applyStimulus(1, 4'd12, 6'h03, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t6_new_valid", b_valid_o, 1);
        checkOutput("t6_new_id", b_id_o, 12);
        checkOutput("t6_new_user", b_user_o, 6'h03);
        step();
        checkOutput("t6_end_valid", b_valid_o, 0);
        checkOutput("t6_end_outst", outstanding_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_b_resp_gen_ipa.md
EXT_B_RESP_GEN_IPA -- requirements
Module: ext_b_resp_gen_ipa

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI transaction ID width.
REQ-002 SHALL have parameter USER_WIDTH, default 6, AXI user sideband width.
REQ-003 SHALL have parameter DEPTH, default 4, outstanding-write capacity; power of two, >= 2.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports aw_valid_i input 1, aw_id_i input ID_WIDTH, aw_user_i input USER_WIDTH, aw_ready_o output 1; accepted write-address info.
REQ-007 SHALL have ports wl_valid_i input 1, wl_err_i input 1, wl_ready_o output 1; write-burst completion (last W beat written), wl_err_i = burst failed.
REQ-008 SHALL have ports b_valid_o output 1, b_resp_o output 2, b_id_o output ID_WIDTH, b_user_o output USER_WIDTH, b_ready_i input 1; generated write response.
REQ-009 SHALL have port outstanding_o  output  $clog2(DEPTH)+1  number of AW entries held, not yet responded.

Function
REQ-010 SHALL store {aw_id_i, aw_user_i} in an in-order AW FIFO of DEPTH entries on aw_valid_i && aw_ready_o.
REQ-011 SHALL store wl_err_i in an in-order completion FIFO of DEPTH entries on wl_valid_i && wl_ready_o.
REQ-012 SHALL drive aw_ready_o = (AW FIFO count != DEPTH), wl_ready_o = (completion FIFO count != DEPTH); no combinational dependence on valid or b_ready_i.
REQ-013 SHALL pair AW and completion entries strictly in arrival order; the Nth completion closes the Nth AW.
REQ-014 SHALL load the B output register when both FIFOs non-empty and (b_valid_o == 0 or b_ready_i == 1), popping one entry from each FIFO in that cycle.
REQ-015 SHALL assert b_valid_o one cycle after the cycle in which both FIFOs first hold a matching pair (minimum latency 1 cycle from the later push).
REQ-016 SHALL sustain one response per cycle while b_ready_i held high and pairs available.
REQ-017 SHALL hold b_valid_o, b_resp_o, b_id_o, b_user_o stable while b_valid_o && !b_ready_i.
REQ-018 SHALL deassert b_valid_o after a handshake when no pair is available.
REQ-019 SHALL allow push and pop of the same FIFO in one cycle; count unchanged; a full FIFO still refuses the push (ready reflects pre-cycle count).
REQ-020 SHALL wrap FIFO read/write pointers modulo DEPTH without loss or duplication.
REQ-021 SHALL update outstanding_o = AW FIFO count plus 1 if b_valid_o; decrements on B handshake.
REQ-022 SHALL tolerate completions arriving before their AW: they wait in the completion FIFO.

Reset
REQ-023 SHALL, while rst_ni low, force b_valid_o=0, b_resp_o=2'b00, b_id_o=0, b_user_o=0, outstanding_o=0, both FIFOs empty, aw_ready_o=1, wl_ready_o=1.
REQ-024 SHALL discard all buffered entries and any pending B on reset assertion mid-operation; no response emitted after release for pre-reset writes.

Configuration
REQ-025 SHALL recognise macro EXT_B_RESP_SLVERR_EN.
REQ-026 SHALL, with EXT_B_RESP_SLVERR_EN defined, drive b_resp_o = 2'b10 (SLVERR) when the paired wl_err_i was 1, else 2'b00.
REQ-027 SHALL, without EXT_B_RESP_SLVERR_EN, ignore wl_err_i, omit the error storage, and drive b_resp_o = 2'b00 always.

Verification
REQ-028 SHALL cover: AW id=3,user=0x15 cycle 0, WL err=0 cycle 2, b_ready_i=1 -> b_valid_o cycle 3, b_id_o=3, b_user_o=0x15, b_resp_o=00, one cycle only.
REQ-029 SHALL cover: 4 AWs ids 1..4, no WL -> aw_ready_o=0 after 4th, 5th AW stalls; then 4 WLs -> B ids 1,2,3,4 in order, outstanding_o 4->0.
REQ-030 SHALL cover: pair ready, b_ready_i=0 for 5 cycles -> b_valid_o held, id/resp unchanged; b_ready_i=1 -> single handshake.
REQ-031 SHALL cover (macro on): WL err sequence 0,1,0 for ids 5,6,7 -> b_resp_o 00,10,00; macro off -> 00,00,00.
REQ-032 SHALL cover: 2 WLs before any AW, then AW ids 9,10 back-to-back with b_ready_i=1 -> B id 9 then 10 on consecutive cycles.
REQ-033 SHALL cover: rst_ni pulsed low with 3 outstanding and b_valid_o=1 -> all outputs at reset values immediately; no B after release until new AW+WL.
